z80_vdp99: RTL and testbench

TMS9918-compatible CPU-side register and VRAM-access engine for the VDP. It decodes Z80 I/O strobes on the data port and the control port, and implements the two-byte control-write protocol. It owns the 8 VDP control registers, the 14-bit auto-incrementing VRAM address pointer with its read-ahead buffer, and the status register and IRQ. It sits between the Z80 bus glue and the VRAM/video generator, which consume its register bus and VRAM port.

---
 rtl/vdp99_pkg.sv | 21 ++
 rtl/vdp99_strobe_edge.sv | 29 ++
 rtl/z80_vdp99.sv | 172 +++++++++++++++++
 tb/tb_z80_vdp99.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vdp99_pkg.sv
// Shared constants for the TMS9918-style CPU interface: VRAM address width,
// register indices, status bit positions and the VRAM access states.
package vdp99_pkg;

    localparam int ADDR_W = 14;

    localparam int REG_MODE0 = 0;
    localparam int REG_MODE1 = 1;
    localparam int IE_BIT    = 5;

    localparam int ST_F  = 7;
    localparam int ST_5S = 6;
    localparam int ST_C  = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD
    } acc_state_t;

endpackage

// File: rtl/vdp99_strobe_edge.sv
// Registers a multi-cycle CPU strobe and flags its rising and falling edges,
// so each strobe triggers exactly one action regardless of its length.
module vdp99_strobe_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= strobe;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/z80_vdp99.sv
// CPU-side register and VRAM-access engine of a TMS9918-compatible VDP:
// two-byte control protocol, R0..R7, auto-incrementing VRAM pointer, status/IRQ.
//
// state   | meaning
// S_IDLE  | waiting for a strobe or a pending post-read prefetch
// S_FETCH | vram_re asserted with vram_addr = pointer
// S_LOAD  | VRAM data valid; load rdbuf and advance the pointer
module z80_vdp99
    import vdp99_pkg::*;
(
    input  logic              phi,
    input  logic              reset,
    input  logic              cpu_mode,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_dout,
    output logic              vram_we,
    input  logic [7:0]        vram_din,
    output logic              vram_re,
    output logic [63:0]       regs,
    input  logic              frame_tick,
    input  logic              coll_set,
    input  logic              fifth_set,
    input  logic [4:0]        fifth_num,
    output logic              irq
);

    acc_state_t        state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        latch_q;
    logic              second;
    logic [7:0]        rdbuf;
    logic [7:0][7:0]   regs_q;
    logic              stat_f, stat_5s, stat_c;
    logic [4:0]        fifth_q;
    logic [7:0]        dout_q;
    logic              rd_pending, rd_status;

    logic wr_lvl, wr_rise, unused_wr_fall;
    logic rd_lvl, rd_rise, rd_fall;
    logic wr_act, rd_act, status_clr;
    logic addr_inc, prefetch_go;
    logic [7:0] status_byte;

    vdp99_strobe_edge u_wr_edge (
        .clk(phi), .rst_n(reset), .strobe(cpu_wr),
        .level(wr_lvl), .rise(wr_rise), .fall(unused_wr_fall)
    );

    vdp99_strobe_edge u_rd_edge (
        .clk(phi), .rst_n(reset), .strobe(cpu_rd),
        .level(rd_lvl), .rise(rd_rise), .fall(rd_fall)
    );

    // Overlapping write and read strobes are bus contention; neither acts.
    assign wr_act     = wr_rise & ~rd_lvl & (state == S_IDLE);
    assign rd_act     = rd_rise & ~wr_lvl & (state == S_IDLE);
    assign status_clr = rd_fall & rd_status;

    always_comb begin
        status_byte         = 8'h00;
        status_byte[ST_F]   = stat_f;
        status_byte[ST_5S]  = stat_5s;
        status_byte[ST_C]   = stat_c;
        status_byte[4:0]    = fifth_q;
    end

    always_comb begin
        state_nxt   = state;
        vram_we     = 1'b0;
        vram_re     = 1'b0;
        addr_inc    = 1'b0;
        prefetch_go = 1'b0;
        case (state)
            S_IDLE: begin
                if (wr_act && !cpu_mode) begin
                    vram_we  = 1'b1;
                    addr_inc = 1'b1;
                end else if (wr_act && cpu_mode && second && !cpu_din[7] && !cpu_din[6]) begin
                    state_nxt = S_FETCH;
                end else if (!wr_act && rd_pending && !rd_lvl) begin
                    prefetch_go = 1'b1;
                    state_nxt   = S_FETCH;
                end
            end
            S_FETCH: begin
                vram_re   = 1'b1;
                state_nxt = S_LOAD;
            end
            S_LOAD: begin
                addr_inc  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge phi or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            latch_q    <= 8'h00;
            second     <= 1'b0;
            rdbuf      <= 8'h00;
            regs_q     <= '0;
            stat_f     <= 1'b0;
            stat_5s    <= 1'b0;
            stat_c     <= 1'b0;
            fifth_q    <= 5'd0;
            dout_q     <= 8'h00;
            rd_pending <= 1'b0;
            rd_status  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (addr_inc)
                addr <= addr + 1'b1;
            if (state == S_LOAD)
                rdbuf <= vram_din;
            if (prefetch_go)
                rd_pending <= 1'b0;

            if (wr_act) begin
                if (!cpu_mode) begin
                    rdbuf  <= cpu_din;
                    second <= 1'b0;
                end else if (!second) begin
                    latch_q <= cpu_din;
                    second  <= 1'b1;
                end else begin
                    second <= 1'b0;
                    if (cpu_din[7])
                        regs_q[cpu_din[2:0]] <= latch_q;
                    else
                        addr <= {cpu_din[5:0], latch_q};
                end
            end

            if (rd_act) begin
                if (cpu_mode) begin
                    dout_q    <= status_byte;
                    rd_status <= 1'b1;
                end else begin
                    dout_q     <= rdbuf;
                    rd_pending <= 1'b1;
                    second     <= 1'b0;
                end
            end

            if (status_clr) begin
                rd_status <= 1'b0;
                second    <= 1'b0;
            end

            // A set pulse coinciding with the status-read clear keeps the flag.
            stat_f  <= frame_tick | (stat_f  & ~status_clr);
            stat_5s <= fifth_set  | (stat_5s & ~status_clr);
            stat_c  <= coll_set   | (stat_c  & ~status_clr);
            if (fifth_set)
                fifth_q <= fifth_num;
        end
    end

    assign vram_addr = addr;
    assign vram_dout = cpu_din;
    assign cpu_dout  = dout_q;
    assign regs      = regs_q;
    assign irq       = stat_f & regs_q[REG_MODE1][IE_BIT];

endmodule

// File: tb/tb_z80_vdp99.sv
// Directed bench for z80_vdp99: Z80 strobe tasks, a small VRAM model and
// hand-computed expectations for registers, VRAM access, status and IRQ.
module tb_z80_vdp99;
    import vdp99_pkg::*;

    logic              phi = 1'b0;
    logic              reset = 1'b0;
    logic              cpu_mode = 1'b0;
    logic [7:0]        cpu_din = 8'h00;
    logic [7:0]        cpu_dout;
    logic              cpu_wr = 1'b0;
    logic              cpu_rd = 1'b0;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_dout;
    logic              vram_we;
    logic [7:0]        vram_din = 8'h00;
    logic              vram_re;
    logic [63:0]       regs;
    logic              frame_tick = 1'b0;
    logic              coll_set = 1'b0;
    logic              fifth_set = 1'b0;
    logic [4:0]        fifth_num = 5'd0;
    logic              irq;

    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    int                we_count = 0;
    logic [ADDR_W-1:0] we_addr = '0;
    logic [7:0]        we_data = 8'h00;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 phi = ~phi;

    z80_vdp99 dut (
        .phi(phi), .reset(reset), .cpu_mode(cpu_mode), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .vram_addr(vram_addr), .vram_dout(vram_dout), .vram_we(vram_we),
        .vram_din(vram_din), .vram_re(vram_re), .regs(regs),
        .frame_tick(frame_tick), .coll_set(coll_set), .fifth_set(fifth_set),
        .fifth_num(fifth_num), .irq(irq)
    );

    // VRAM model, sampled mid-cycle so it never races the DUT clock edge.
    always @(negedge phi) begin
        if (vram_we) begin
            mem[vram_addr] <= vram_dout;
            we_count       <= we_count + 1;
            we_addr        <= vram_addr;
            we_data        <= vram_dout;
        end
        if (vram_re)
            vram_din <= mem[vram_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cpu_write(input logic mode, input logic [7:0] data, input int len = 4);
        @(posedge phi); #1;
        cpu_mode = mode;
        cpu_din  = data;
        cpu_wr   = 1'b1;
        repeat (len) @(posedge phi);
        #1 cpu_wr = 1'b0;
        repeat (6) @(posedge phi);
    endtask

    task automatic cpu_read(input logic mode, output logic [7:0] data);
        @(posedge phi); #1;
        cpu_mode = mode;
        cpu_rd   = 1'b1;
        repeat (4) @(posedge phi);
        #1 data = cpu_dout;
        cpu_rd = 1'b0;
        repeat (6) @(posedge phi);
    endtask

    task automatic pulse_frame();
        @(posedge phi); #1 frame_tick = 1'b1;
        @(posedge phi); #1 frame_tick = 1'b0;
        repeat (2) @(posedge phi);
        #1;
    endtask

    logic [7:0] rd_val;
    logic [7:0] reg_pairs [16];
    int         we_base;

    initial begin
        reg_pairs = '{8'h40, 8'h81, 8'h02, 8'h82, 8'h30, 8'h83, 8'h00, 8'h84,
                      8'hFF, 8'h85, 8'hFF, 8'h86, 8'h34, 8'h87, 8'h00, 8'h00};

        repeat (3) @(posedge phi);
        #1 reset = 1'b1;
        repeat (2) @(posedge phi);
        #1;
        check("reset_regs", regs, 64'h0);
        check("reset_dout", cpu_dout, 8'h00);
        check("reset_irq", irq, 1'b0);
        check("reset_addr", vram_addr, 14'h0000);
        check("reset_we_re", {vram_we, vram_re}, 2'b00);

        // Register update latency: 2 cycles after cpu_wr rises.
        cpu_write(1'b1, 8'h5C);
        @(posedge phi); #1;
        cpu_mode = 1'b1; cpu_din = 8'h82; cpu_wr = 1'b1;
        @(posedge phi); #1;
        check("r2_one_cycle", regs[23:16], 8'h00);
        @(posedge phi); #1;
        check("r2_two_cycles", regs[23:16], 8'h5C);
        repeat (3) @(posedge phi);
        #1 cpu_wr = 1'b0;
        repeat (6) @(posedge phi);

        cpu_write(1'b1, 8'h02);
        cpu_write(1'b1, 8'h80);
        check("r0_write", regs[7:0], 8'h02);
        for (int i = 0; i < 7; i++) begin
            cpu_write(1'b1, reg_pairs[2*i]);
            cpu_write(1'b1, reg_pairs[2*i+1]);
        end
        check("regs_all", regs, 64'h34FFFF0030024002);

        // VRAM write with a long strobe: exactly one write.
        cpu_write(1'b1, 8'h00);
        cpu_write(1'b1, 8'h48);
        #1 check("wsetup_addr", vram_addr, 14'h0800);
        we_base = we_count;
        cpu_write(1'b0, 8'h41, 20);
        check("write_once", we_count - we_base, 1);
        check("write_addr", we_addr, 14'h0800);
        check("write_data", we_data, 8'h41);
        check("write_inc", vram_addr, 14'h0801);

        // VRAM read: preload through data writes, then read setup.
        cpu_write(1'b1, 8'h00);
        cpu_write(1'b1, 8'h48);
        cpu_write(1'b0, 8'h5A);
        cpu_write(1'b0, 8'hA5);
        cpu_write(1'b1, 8'h00);
        cpu_write(1'b1, 8'h08);
        check("rsetup_addr", vram_addr, 14'h0801);
        cpu_read(1'b0, rd_val);
        check("read_first", rd_val, 8'h5A);
        check("read_dout_hold", cpu_dout, 8'h5A);
        cpu_read(1'b0, rd_val);
        check("read_second", rd_val, 8'hA5);
        check("read_addr_after", vram_addr, 14'h0803);

        // Frame interrupt with IE on.
        cpu_write(1'b1, 8'h60);
        cpu_write(1'b1, 8'h81);
        pulse_frame();
        check("irq_set", irq, 1'b1);
        cpu_read(1'b1, rd_val);
        check("status_frame", rd_val, 8'h80);
        check("irq_cleared", irq, 1'b0);
        cpu_read(1'b1, rd_val);
        check("status_after_clear", rd_val, 8'h00);

        // Frame flag with IE off.
        cpu_write(1'b1, 8'h40);
        cpu_write(1'b1, 8'h81);
        pulse_frame();
        check("irq_ie_off", irq, 1'b0);
        cpu_read(1'b1, rd_val);
        check("status_ie_off", rd_val, 8'h80);

        // Fifth sprite flag and number.
        @(posedge phi); #1 fifth_num = 5'h13; fifth_set = 1'b1;
        @(posedge phi); #1 fifth_set = 1'b0;
        cpu_read(1'b1, rd_val);
        check("status_fifth", rd_val, 8'h53);
        cpu_read(1'b1, rd_val);
        check("status_fifth_clr", rd_val, 8'h13);

        // Collision set in the same cycle as the status clear survives.
        @(posedge phi); #1;
        cpu_mode = 1'b1; cpu_rd = 1'b1;
        repeat (4) @(posedge phi);
        #1 check("status_hold", cpu_dout, 8'h13);
        cpu_rd = 1'b0;
        @(posedge phi); #1 coll_set = 1'b1;
        @(posedge phi); #1 coll_set = 1'b0;
        repeat (4) @(posedge phi);
        cpu_read(1'b1, rd_val);
        check("coll_wins", rd_val, 8'h33);
        cpu_read(1'b1, rd_val);
        check("coll_cleared", rd_val, 8'h13);

        // Status read discards a dangling first control byte.
        cpu_write(1'b1, 8'h12);
        cpu_read(1'b1, rd_val);
        cpu_write(1'b1, 8'h00);
        cpu_write(1'b1, 8'h48);
        check("latch_reset_addr", vram_addr, 14'h0800);

        // Address wrap.
        cpu_write(1'b1, 8'hFF);
        cpu_write(1'b1, 8'h7F);
        check("wrap_setup", vram_addr, 14'h3FFF);
        cpu_write(1'b0, 8'h99);
        check("wrap_write_addr", we_addr, 14'h3FFF);
        check("wrap_addr", vram_addr, 14'h0000);

        // Simultaneous strobes are ignored; protocol stays byte-aligned.
        @(posedge phi); #1;
        cpu_mode = 1'b1; cpu_din = 8'h77; cpu_wr = 1'b1; cpu_rd = 1'b1;
        repeat (4) @(posedge phi);
        #1 cpu_wr = 1'b0; cpu_rd = 1'b0;
        repeat (6) @(posedge phi);
        cpu_write(1'b1, 8'h55);
        cpu_write(1'b1, 8'h83);
        check("both_strobes_ignored", regs[31:24], 8'h55);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
